// File: rtl/subsoc_wb_arb2.sv
// Two-initiator Wishbone arbiter: round-robin grant held for a whole CYC,
// with a per-transfer watchdog that terminates hung transfers with ERR.
module subsoc_wb_arb2 #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            i0_wb_cyc_i,
    input  logic            i0_wb_stb_i,
    input  logic            i0_wb_we_i,
    input  logic [AW-1:0]   i0_wb_adr_i,
    input  logic [DW/8-1:0] i0_wb_sel_i,
    input  logic [DW-1:0]   i0_wb_dat_i,
    output logic [DW-1:0]   i0_wb_dat_o,
    output logic            i0_wb_ack_o,
    output logic            i0_wb_err_o,

    input  logic            i1_wb_cyc_i,
    input  logic            i1_wb_stb_i,
    input  logic            i1_wb_we_i,
    input  logic [AW-1:0]   i1_wb_adr_i,
    input  logic [DW/8-1:0] i1_wb_sel_i,
    input  logic [DW-1:0]   i1_wb_dat_i,
    output logic [DW-1:0]   i1_wb_dat_o,
    output logic            i1_wb_ack_o,
    output logic            i1_wb_err_o,

    output logic            t_wb_cyc_o,
    output logic            t_wb_stb_o,
    output logic            t_wb_we_o,
    output logic [AW-1:0]   t_wb_adr_o,
    output logic [DW/8-1:0] t_wb_sel_o,
    output logic [DW-1:0]   t_wb_dat_o,
    input  logic [DW-1:0]   t_wb_dat_i,
    input  logic            t_wb_ack_i,

    output logic [1:0]      gnt_o,
    output logic            to_flag_o,
    input  logic            to_clr_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G0   = 2'd1;
    localparam logic [1:0] G1   = 2'd2;

    // A zero limit disables the watchdog; the compare value is then irrelevant.
    localparam logic        WD_EN    = (TO_CYC != 0);
    localparam logic [15:0] WD_LIMIT = (TO_CYC == 0) ? 16'd0 : 16'(TO_CYC - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        last;
    logic [15:0] wd;
    logic        sel0;
    logic        sel1;
    logic        in_cyc;
    logic        in_stb;
    logic        to_fire;

    assign sel0  = (state == G0);
    assign sel1  = (state == G1);
    assign gnt_o = {sel1, sel0};

    always_comb begin
        in_cyc     = 1'b0;
        in_stb     = 1'b0;
        t_wb_we_o  = 1'b0;
        t_wb_adr_o = '0;
        t_wb_sel_o = '0;
        t_wb_dat_o = '0;
        if (sel0) begin
            in_cyc     = i0_wb_cyc_i;
            in_stb     = i0_wb_stb_i;
            t_wb_we_o  = i0_wb_we_i;
            t_wb_adr_o = i0_wb_adr_i;
            t_wb_sel_o = i0_wb_sel_i;
            t_wb_dat_o = i0_wb_dat_i;
        end else if (sel1) begin
            in_cyc     = i1_wb_cyc_i;
            in_stb     = i1_wb_stb_i;
            t_wb_we_o  = i1_wb_we_i;
            t_wb_adr_o = i1_wb_adr_i;
            t_wb_sel_o = i1_wb_sel_i;
            t_wb_dat_o = i1_wb_dat_i;
        end
    end

    // An ack in the would-be timeout cycle wins: the transfer completes normally.
    assign to_fire = WD_EN & (wd == WD_LIMIT) & in_stb & ~t_wb_ack_i;

    assign t_wb_cyc_o  = in_cyc;
    assign t_wb_stb_o  = in_stb & ~to_fire;

    assign i0_wb_dat_o = t_wb_dat_i;
    assign i1_wb_dat_o = t_wb_dat_i;
    assign i0_wb_ack_o = sel0 & t_wb_ack_i;
    assign i1_wb_ack_o = sel1 & t_wb_ack_i;
    assign i0_wb_err_o = sel0 & to_fire;
    assign i1_wb_err_o = sel1 & to_fire;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (i0_wb_cyc_i && i1_wb_cyc_i) state_nxt = last ? G0 : G1;
                else if (i0_wb_cyc_i)           state_nxt = G0;
                else if (i1_wb_cyc_i)           state_nxt = G1;
                else                            state_nxt = IDLE;
            end
            G0: begin
                if (i0_wb_cyc_i)      state_nxt = G0;
                else if (i1_wb_cyc_i) state_nxt = G1;
                else                  state_nxt = IDLE;
            end
            G1: begin
                if (i1_wb_cyc_i)      state_nxt = G1;
                else if (i0_wb_cyc_i) state_nxt = G0;
                else                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            last      <= 1'b1;
            wd        <= 16'd0;
            to_flag_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state && state_nxt == G0) last <= 1'b0;
            if (state_nxt != state && state_nxt == G1) last <= 1'b1;

            if (state_nxt != state || !in_stb || t_wb_ack_i || to_fire)
                wd <= 16'd0;
            else
                wd <= wd + 16'd1;

            if (to_fire)       to_flag_o <= 1'b1;
            else if (to_clr_i) to_flag_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_subsoc_wb_arb2.sv
// Bench for subsoc_wb_arb2: vector table, hand-written watchdog/reset sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_subsoc_wb_arb2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cyc  [2];
    logic          stb  [2];
    logic          we   [2];
    logic [AW-1:0] adr  [2];
    logic [SW-1:0] sel  [2];
    logic [DW-1:0] wdat [2];
    logic [DW-1:0] t_rdat;
    logic          t_ack;
    logic          to_clr;

    logic [DW-1:0] rd0, rd1, t_wdat;
    logic          ack0, ack1, err0, err1, t_cyc, t_stb, t_we, flag;
    logic [AW-1:0] t_adr;
    logic [SW-1:0] t_sel;
    logic [1:0]    gnt;

    logic [DW-1:0] n_rd0, n_rd1, n_wdat;
    logic          n_ack0, n_ack1, n_err0, n_err1, n_cyc, n_stb, n_we, n_flag;
    logic [AW-1:0] n_adr;
    logic [SW-1:0] n_sel;
    logic [1:0]    n_gnt;

    subsoc_wb_arb2 #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .i0_wb_cyc_i(cyc[0]), .i0_wb_stb_i(stb[0]), .i0_wb_we_i(we[0]),
        .i0_wb_adr_i(adr[0]), .i0_wb_sel_i(sel[0]), .i0_wb_dat_i(wdat[0]),
        .i0_wb_dat_o(rd0), .i0_wb_ack_o(ack0), .i0_wb_err_o(err0),
        .i1_wb_cyc_i(cyc[1]), .i1_wb_stb_i(stb[1]), .i1_wb_we_i(we[1]),
        .i1_wb_adr_i(adr[1]), .i1_wb_sel_i(sel[1]), .i1_wb_dat_i(wdat[1]),
        .i1_wb_dat_o(rd1), .i1_wb_ack_o(ack1), .i1_wb_err_o(err1),
        .t_wb_cyc_o(t_cyc), .t_wb_stb_o(t_stb), .t_wb_we_o(t_we),
        .t_wb_adr_o(t_adr), .t_wb_sel_o(t_sel), .t_wb_dat_o(t_wdat),
        .t_wb_dat_i(t_rdat), .t_wb_ack_i(t_ack),
        .gnt_o(gnt), .to_flag_o(flag), .to_clr_i(to_clr)
    );

    // Same stimulus, watchdog disabled.
    subsoc_wb_arb2 #(.AW(AW), .DW(DW), .TO_CYC(0)) dut_nto (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .i0_wb_cyc_i(cyc[0]), .i0_wb_stb_i(stb[0]), .i0_wb_we_i(we[0]),
        .i0_wb_adr_i(adr[0]), .i0_wb_sel_i(sel[0]), .i0_wb_dat_i(wdat[0]),
        .i0_wb_dat_o(n_rd0), .i0_wb_ack_o(n_ack0), .i0_wb_err_o(n_err0),
        .i1_wb_cyc_i(cyc[1]), .i1_wb_stb_i(stb[1]), .i1_wb_we_i(we[1]),
        .i1_wb_adr_i(adr[1]), .i1_wb_sel_i(sel[1]), .i1_wb_dat_i(wdat[1]),
        .i1_wb_dat_o(n_rd1), .i1_wb_ack_o(n_ack1), .i1_wb_err_o(n_err1),
        .t_wb_cyc_o(n_cyc), .t_wb_stb_o(n_stb), .t_wb_we_o(n_we),
        .t_wb_adr_o(n_adr), .t_wb_sel_o(n_sel), .t_wb_dat_o(n_wdat),
        .t_wb_dat_i(t_rdat), .t_wb_ack_i(t_ack),
        .gnt_o(n_gnt), .to_flag_o(n_flag), .to_clr_i(to_clr)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: owner of the bus (-1 none), last served, stalled-cycle count, sticky flag.
    typedef struct packed {
        logic [1:0]    gnt;
        logic          tcyc, tstb, twe;
        logic [AW-1:0] tadr;
        logic [SW-1:0] tsel;
        logic [DW-1:0] tdat;
        logic [1:0]    ack, err;
    } exp_t;

    int   m_owner = -1;
    logic m_last  = 1'b1;
    int   m_stall = 0;
    logic m_flag  = 1'b0;
    int   n_owner, n_stall;
    logic n_last, n_flagm, m_s, m_fire, ob;
    exp_t e;

    always_comb begin
        e      = '0;
        m_s    = 1'b0;
        m_fire = 1'b0;
        ob     = (m_owner == 1);
        if (m_owner >= 0) begin
            m_s         = stb[ob];
            m_fire      = m_s && !t_ack && (m_stall + 1 == TO);
            e.gnt       = ob ? 2'b10 : 2'b01;
            e.tcyc      = cyc[ob];
            e.tstb      = m_s && !m_fire;
            e.twe       = we[ob];
            e.tadr      = adr[ob];
            e.tsel      = sel[ob];
            e.tdat      = wdat[ob];
            e.ack[ob]   = t_ack;
            e.err[ob]   = m_fire;
        end
        if (m_owner >= 0) begin
            if (cyc[ob])       n_owner = m_owner;
            else if (cyc[!ob]) n_owner = 1 - m_owner;
            else               n_owner = -1;
        end else if (cyc[0] && cyc[1]) n_owner = m_last ? 0 : 1;
        else if (cyc[0])               n_owner = 0;
        else if (cyc[1])               n_owner = 1;
        else                           n_owner = -1;
        n_last  = (n_owner >= 0 && n_owner != m_owner) ? n_owner[0] : m_last;
        n_stall = (n_owner != m_owner || !m_s || t_ack || m_fire) ? 0 : m_stall + 1;
        n_flagm = m_fire ? 1'b1 : (to_clr ? 1'b0 : m_flag);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= -1;
            m_last  <= 1'b1;
            m_stall <= 0;
            m_flag  <= 1'b0;
        end else begin
            m_owner <= n_owner;
            m_last  <= n_last;
            m_stall <= n_stall;
            m_flag  <= n_flagm;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, c0, s0, c1, s1, a,
                                 input logic [DW-1:0] rd, input logic clr);
        rst    = r;
        cyc[0] = c0; stb[0] = s0;
        cyc[1] = c1; stb[1] = s1;
        t_ack  = a;
        t_rdat = rd;
        to_clr = clr;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic          rst, c0, s0, c1, s1, ack;
        logic [DW-1:0] rdat;
        logic [1:0]    gnt;
        logic          tcyc, tstb, a0, a1;
    } vec_t;

    function automatic vec_t mk(input logic r, c0, s0, c1, s1, a, input logic [DW-1:0] rd,
                                input logic [1:0] g, input logic tc, ts, a0, a1);
        vec_t v;
        v = '{r, c0, s0, c1, s1, a, rd, g, tc, ts, a0, a1};
        return v;
    endfunction

    vec_t vecs [$];
    vec_t v;
    logic [AW-1:0] x_adr;
    logic [SW-1:0] x_sel;
    logic [DW-1:0] x_wd;

    initial begin
        // Single master read, then reset, simultaneous request, handover, round-robin, burst hold.
        vecs.push_back(mk(0,1,1,0,0,0,32'h0,        2'b00,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,0,32'h0,        2'b01,1,1,0,0));
        vecs.push_back(mk(0,1,1,0,0,0,32'h0,        2'b01,1,1,0,0));
        vecs.push_back(mk(0,1,1,0,0,1,32'hCAFEF00D, 2'b01,1,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        2'b01,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        2'b00,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,32'h0,        2'b00,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,1,0,32'h0,        2'b00,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,1,0,32'h0,        2'b01,1,1,0,0));
        vecs.push_back(mk(0,1,1,1,1,1,32'h11112222, 2'b01,1,1,1,0));
        vecs.push_back(mk(0,0,0,1,1,0,32'h0,        2'b01,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0,32'h0,        2'b10,1,1,0,0));
        vecs.push_back(mk(0,0,0,1,1,1,32'h33334444, 2'b10,1,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        2'b10,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        2'b00,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,1,0,32'h0,        2'b00,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,1,0,32'h0,        2'b01,1,1,0,0));
        vecs.push_back(mk(0,1,1,1,1,1,32'h55556666, 2'b01,1,1,1,0));
        vecs.push_back(mk(0,0,0,1,1,0,32'h0,        2'b01,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0,32'h0,        2'b10,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        2'b10,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        2'b00,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0,32'h0,        2'b00,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,1,1,32'hA0A0A0A0, 2'b10,1,1,0,1));
        vecs.push_back(mk(0,1,1,1,1,1,32'hA1A1A1A1, 2'b10,1,1,0,1));
        vecs.push_back(mk(0,1,1,1,1,1,32'hA2A2A2A2, 2'b10,1,1,0,1));
        vecs.push_back(mk(0,1,1,1,1,1,32'hA3A3A3A3, 2'b10,1,1,0,1));
        vecs.push_back(mk(0,1,1,0,0,0,32'h0,        2'b10,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,0,32'h0,        2'b01,1,1,0,0));
        vecs.push_back(mk(0,1,1,0,0,1,32'hB0B0B0B0, 2'b01,1,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        2'b01,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        2'b00,0,0,0,0));

        we[0] = 1'b0; adr[0] = 32'h100; sel[0] = 4'h3; wdat[0] = 32'hD0D0D0D0;
        we[1] = 1'b1; adr[1] = 32'h200; sel[1] = 4'hC; wdat[1] = 32'hD1D1D1D1;
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0);
        nextEdge();
        nextEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("reset gnt", gnt, 2'b00);
        checkOutput("reset t_cyc", t_cyc, 1'b0);
        checkOutput("reset t_adr", t_adr, 32'h0);
        checkOutput("reset flag", flag, 1'b0);
        nextEdge();

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.rst, v.c0, v.s0, v.c1, v.s1, v.ack, v.rdat, 0);
            x_adr = (v.gnt == 2'b01) ? 32'h100 : (v.gnt == 2'b10) ? 32'h200 : 32'h0;
            x_sel = (v.gnt == 2'b01) ? 4'h3 : (v.gnt == 2'b10) ? 4'hC : 4'h0;
            x_wd  = (v.gnt == 2'b01) ? 32'hD0D0D0D0 : (v.gnt == 2'b10) ? 32'hD1D1D1D1 : 32'h0;
            @(negedge clk);
            checkOutput($sformatf("vec%0d gnt", i), gnt, v.gnt);
            checkOutput($sformatf("vec%0d t_cyc", i), t_cyc, v.tcyc);
            checkOutput($sformatf("vec%0d t_stb", i), t_stb, v.tstb);
            checkOutput($sformatf("vec%0d t_we", i), t_we, v.gnt[1]);
            checkOutput($sformatf("vec%0d t_adr", i), t_adr, x_adr);
            checkOutput($sformatf("vec%0d t_sel", i), t_sel, x_sel);
            checkOutput($sformatf("vec%0d t_dat", i), t_wdat, x_wd);
            checkOutput($sformatf("vec%0d ack0", i), ack0, v.a0);
            checkOutput($sformatf("vec%0d ack1", i), ack1, v.a1);
            checkOutput($sformatf("vec%0d errs", i), {err1, err0}, 2'b00);
            checkOutput($sformatf("vec%0d dat0", i), rd0, v.rdat);
            checkOutput($sformatf("vec%0d dat1", i), rd1, v.rdat);
            nextEdge();
        end

        // Watchdog fires on stall cycle 8; clear in the same cycle loses to set.
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0);
        nextEdge();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, 1, 0, 0, 0, 32'h0, (k == 8));
            @(negedge clk);
            checkOutput($sformatf("wd%0d err0", k), err0, (k == 8));
            checkOutput($sformatf("wd%0d t_stb", k), t_stb, (k >= 1 && k != 8));
            checkOutput($sformatf("wd%0d flag", k), flag, (k == 9));
            nextEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1);
        @(negedge clk);
        checkOutput("wd clr cycle flag", flag, 1'b1);
        nextEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("wd cleared flag", flag, 1'b0);
        nextEdge();
        for (int j = 0; j < 9; j++) begin
            applyStimulus(0, 1, 1, 0, 0, (j == 8), 32'hACED0008, 0);
            @(negedge clk);
            checkOutput($sformatf("wdack%0d ack0", j), ack0, (j == 8));
            checkOutput($sformatf("wdack%0d err0", j), err0, 1'b0);
            checkOutput($sformatf("wdack%0d t_stb", j), t_stb, (j >= 1));
            nextEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("wdack flag", flag, 1'b0);
        nextEdge();

        // Reset while i1 owns the bus mid-transfer.
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0);
        nextEdge();
        applyStimulus(0, 0, 0, 1, 1, 0, 32'h0, 0);
        nextEdge();
        applyStimulus(1, 0, 0, 1, 1, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("rstmid pre gnt", gnt, 2'b10);
        nextEdge();
        applyStimulus(0, 1, 1, 1, 1, 1, 32'h0, 0);
        @(negedge clk);
        checkOutput("rstmid gnt", gnt, 2'b00);
        checkOutput("rstmid t_cyc", t_cyc, 1'b0);
        checkOutput("rstmid acks", {ack1, ack0}, 2'b00);
        checkOutput("rstmid errs", {err1, err0}, 2'b00);
        nextEdge();
        applyStimulus(0, 1, 1, 1, 1, 0, 32'h0, 0);
        @(negedge clk);
        checkOutput("rstmid tie gnt", gnt, 2'b01);
        nextEdge();

        // Watchdog disabled: long stall never errors.
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0);
        nextEdge();
        for (int k = 0; k < 1002; k++) begin
            applyStimulus(0, 1, 1, 0, 0, 0, 32'h0, 0);
            @(negedge clk);
            checkOutput($sformatf("nto%0d err0", k), n_err0, 1'b0);
            nextEdge();
        end
        @(negedge clk);
        checkOutput("nto flag", n_flag, 1'b0);
        checkOutput("nto t_stb", n_stb, 1'b1);
        checkOutput("to8 flag", flag, 1'b1);
        nextEdge();

        // Randomized traffic against the reference model.
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0);
        nextEdge();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(7) == 0) cyc[i[0]] = ~cyc[i[0]];
                stb[i[0]]  = cyc[i[0]] && ($urandom_range(3) != 0);
                we[i[0]]   = 1'($urandom_range(1));
                adr[i[0]]  = $urandom;
                sel[i[0]]  = 4'($urandom_range(15));
                wdat[i[0]] = $urandom;
            end
            t_ack  = ($urandom_range(4) == 0);
            t_rdat = $urandom;
            to_clr = ($urandom_range(15) == 0);
            rst    = ($urandom_range(199) == 0);
            @(negedge clk);
            checkOutput($sformatf("rnd%0d gnt", n), gnt, e.gnt);
            checkOutput($sformatf("rnd%0d t_cyc", n), t_cyc, e.tcyc);
            checkOutput($sformatf("rnd%0d t_stb", n), t_stb, e.tstb);
            checkOutput($sformatf("rnd%0d t_we", n), t_we, e.twe);
            checkOutput($sformatf("rnd%0d t_adr", n), t_adr, e.tadr);
            checkOutput($sformatf("rnd%0d t_sel", n), t_sel, e.tsel);
            checkOutput($sformatf("rnd%0d t_dat", n), t_wdat, e.tdat);
            checkOutput($sformatf("rnd%0d acks", n), {ack1, ack0}, e.ack);
            checkOutput($sformatf("rnd%0d errs", n), {err1, err0}, e.err);
            checkOutput($sformatf("rnd%0d flag", n), flag, m_flag);
            checkOutput($sformatf("rnd%0d rdat", n), {rd1, rd0}, {t_rdat, t_rdat});
            nextEdge();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/subsoc_wb_arb2.md
# subsoc_wb_arb2

Two-initiator Wishbone arbiter that shares one Wishbone target port between the OR1200 data master and instruction master. It sits between the CPU masters and a single shared slave, such as the on-chip RAM or the SFIFO_IF, when that slave is moved off the traffic cop. Arbitration is round-robin, and the grant is held for the whole bus cycle (CYC). A per-transfer watchdog terminates hung transfers with an error and sets a sticky flag.

## Interface
- AW, 32, address width
- DW, 32, data width (SEL width = DW/8)
- TO_CYC, 255, watchdog limit in cycles (stb high with no ack); 0 disables the watchdog; must be < 2^16
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset; synchronous, active-high
- i0_wb_cyc_i, i0_wb_stb_i, i0_wb_we_i  in  1 each  initiator 0 (data master) control
- i0_wb_adr_i  in  AW  initiator 0 address
- i0_wb_sel_i  in  DW/8  initiator 0 byte select
- i0_wb_dat_i  in  DW  initiator 0 write data
- i0_wb_dat_o  out  DW  read data to initiator 0
- i0_wb_ack_o, i0_wb_err_o  out  1 each  termination to initiator 0
- i1_wb_*  same set as i0_wb_*, for initiator 1 (instruction master)
- t_wb_cyc_o, t_wb_stb_o, t_wb_we_o  out  1 each  target control
- t_wb_adr_o  out  AW  target address
- t_wb_sel_o  out  DW/8  target byte select
- t_wb_dat_o  out  DW  target write data
- t_wb_dat_i  in  DW  target read data
- t_wb_ack_i  in  1  target acknowledge
- gnt_o  out  2  one-hot current grant; 00 = idle
- to_flag_o  out  1  sticky watchdog-fired flag
- to_clr_i  in  1  clears to_flag_o

## Operation
- State machine: IDLE, G0, G1. The state is registered. gnt_o = {state==G1, state==G0}.
- Register `last` holds the last-served initiator. It resets to 1, so i0 wins the first tie.
- IDLE:
  - i0_cyc only -> G0.
  - i1_cyc only -> G1.
  - both -> the initiator that is not `last`.
  - none -> stay in IDLE.
- On entry to Gn, `last` <= n.
- Gn with in_cyc high: stay. No preemption.
- Gn with in_cyc low: go directly to G(other) if the other initiator's cyc is high, else IDLE.
- Target outputs are combinational from the granted initiator:
  - t_cyc_o = gnt & in_cyc.
  - t_stb_o = gnt & in_stb & ~to_fire.
  - adr, sel, we, dat are muxed from the granted initiator.
  - In IDLE all target outputs are 0.
- Both i0_wb_dat_o and i1_wb_dat_o = t_wb_dat_i (broadcast).
- in_ack_o = gnt_n & t_wb_ack_i. The non-granted initiator never sees ack or err.
- Watchdog (16-bit counter `wd`):
  - Increments while the granted stb is high and t_wb_ack_i is low.
  - Clears on ack, on stb low, or on any state change.
- to_fire = (TO_CYC != 0) & (wd == TO_CYC-1) & stb & ~ack.
- On to_fire:
  - in_err_o = 1 for that cycle to the granted initiator.
  - t_stb_o is forced to 0.
  - wd clears.
  - to_flag_o sets on the next edge.
- to_clr_i clears to_flag_o. If to_fire and to_clr_i occur in the same cycle, set wins.
- A t_wb_ack_i arriving in the same cycle as to_fire counts as an ack: to_fire is suppressed by ~ack.
- t_wb_ack_i in IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE, last = 1, wd = 0, to_flag_o = 0, gnt_o = 00.
  - All t_* outputs, ack_o and err_o = 0.
- Arbitration latency: the first cycle with cyc requested from IDLE goes to the decision. t_cyc_o asserts 1 cycle after i*_cyc_i rises.
- Handover: when the granted initiator drops cyc while the other is waiting, the target sees exactly 1 idle cycle (t_cyc_o = 0) before the new grant drives the bus.
- Ack and data paths are purely combinational: single-cycle and pipelined-ack slaves pass through unchanged.
- Timeout fires on the TO_CYC-th consecutive cycle of stb high without ack.
- Reset asserted mid-transfer: the next edge forces IDLE and drops t_cyc_o. The pending transfer is lost, and no ack or err is issued.

## Test plan
- **Single master:** i0 issues a read to 0x100 and the target acks after 2 cycles with 0xCAFEF00D.
  - t_cyc_o rises 1 cycle after i0_cyc.
  - i0_ack_o pulses once and i0_dat_o = 0xCAFEF00D.
  - gnt_o = 01, then 00 after i0 drops cyc.
  - i1_ack_o stays 0 throughout.
- **Simultaneous request after reset:** i0 and i1 raise cyc in the same cycle.
  - i0 is granted first.
  - On i0 cyc drop, gnt goes directly 01 -> 10 with one t_cyc_o = 0 gap.
  - A further simultaneous request then grants i0 (round-robin).
- **Burst hold:** i1 holds cyc across 4 acked transfers while i0 requests.
  - gnt stays 10 for all 4 transfers. There is no preemption.
  - i0 is served after i1 releases.
- **Watchdog:** TO_CYC = 8, i0 stb is held high and the target never acks.
  - i0_err_o pulses in cycle 8 of stb, with t_stb_o = 0 that cycle.
  - to_flag_o = 1 from the next cycle.
  - to_clr_i clears the flag.
  - Re-run with ack arriving exactly in cycle 8: the ack is delivered and no err is raised.
- **Reset mid-transfer:** assert wb_rst_i while in G1 with stb high.
  - Next cycle: gnt_o = 00, t_cyc_o = 0, `last` = 1.
  - A subsequent tie grants i0.
- **TO_CYC = 0:** stb is held for 1000 cycles without ack.
  - No err is raised and to_flag_o stays 0.
